ipsxe_fft_spectrum_buf: RTL and testbench

IPSXE_FFT_SPECTRUM_BUF -- requirements
Module: ipsxe_fft_spectrum_buf

---
 rtl/ipsxe_fft_spectrum_buf.sv | 177 +++++++++++++++++
 tb/tb_ipsxe_fft_spectrum_buf.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ipsxe_fft_spectrum_buf.sv
// Ping-pong magnitude buffer behind the FFT core: collects one frame of
// |X[k]| estimates into the hidden bank and swaps it to the display side.
module ipsxe_fft_spectrum_buf #(
    parameter  int LOG2_FFT_LEN = 8,
    parameter  int OUTPUT_WIDTH = 24,
    parameter  int MAG_WIDTH    = 16,
    parameter  int MAG_SHIFT    = 8,
    localparam int DOUT_WIDTH   = ((OUTPUT_WIDTH + 7) / 8) * 8
) (
    input  logic                      i_aclk,
    input  logic                      i_areset,
    input  logic                      i_aclken,
    input  logic                      i_axi4s_data_tvalid,
    input  logic [2*DOUT_WIDTH-1:0]   i_axi4s_data_tdata,
    input  logic                      i_axi4s_data_tlast,
    output logic                      o_axi4s_data_tready,
    input  logic [LOG2_FFT_LEN-1:0]   i_rd_addr,
    output logic [MAG_WIDTH-1:0]      o_rd_data,
    output logic                      o_bank,
    output logic                      o_frame_done,
    output logic                      o_err_tlast
);

    localparam int N     = 1 << LOG2_FFT_LEN;
    localparam int SUM_W = OUTPUT_WIDTH + 1;
    localparam int CMP_W = (SUM_W > MAG_WIDTH) ? SUM_W : MAG_WIDTH;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FLUSH   = 2'd1,
        SWAP    = 2'd2
    } state_t;

    state_t                    state, state_next;
    logic [LOG2_FFT_LEN-1:0]   wr_idx, wr_idx_next;
    logic                      flush_cnt, flush_cnt_next;
    logic                      err_set;
    logic                      swap;
    logic                      run;
    logic                      xfer;

    logic [OUTPUT_WIDTH-1:0]   re_raw, im_raw;
    logic [OUTPUT_WIDTH-1:0]   re_abs, im_abs;
    logic                      s1_valid;
    logic [OUTPUT_WIDTH-1:0]   s1_a, s1_b;
    logic [LOG2_FFT_LEN-1:0]   s1_addr;
    logic [OUTPUT_WIDTH-1:0]   mag_max, mag_min;
    logic [SUM_W-1:0]          mag_sum;
    logic [CMP_W-1:0]          mag_shifted;
    logic [CMP_W-1:0]          mag_limit;
    logic [MAG_WIDTH-1:0]      mag_sat;
    logic                      s2_valid;
    logic [MAG_WIDTH-1:0]      s2_mag;
    logic [LOG2_FFT_LEN-1:0]   s2_addr;
    logic                      rd_bank;

    logic [MAG_WIDTH-1:0]      mem [0:2*N-1];

    // run holds tready low through the reset cycle itself
    assign o_axi4s_data_tready = run && (state == COLLECT);
    assign xfer = i_aclken && i_axi4s_data_tvalid && o_axi4s_data_tready;

    always_comb begin
        state_next     = state;
        wr_idx_next    = wr_idx;
        flush_cnt_next = flush_cnt;
        err_set        = 1'b0;
        swap           = 1'b0;
        case (state)
            COLLECT: begin
                if (xfer) begin
                    if (&wr_idx) begin
                        state_next     = FLUSH;
                        wr_idx_next    = '0;
                        flush_cnt_next = 1'b0;
                        err_set        = !i_axi4s_data_tlast;
                    end else if (i_axi4s_data_tlast) begin
                        wr_idx_next = '0;
                        err_set     = 1'b1;
                    end else begin
                        wr_idx_next = wr_idx + LOG2_FFT_LEN'(1);
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt) begin
                    state_next = SWAP;
                end else begin
                    flush_cnt_next = 1'b1;
                end
            end
            SWAP: begin
                state_next = COLLECT;
                swap       = 1'b1;
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            state        <= COLLECT;
            wr_idx       <= '0;
            flush_cnt    <= 1'b0;
            o_bank       <= 1'b0;
            o_frame_done <= 1'b0;
            o_err_tlast  <= 1'b0;
            run          <= 1'b0;
        end else begin
            run          <= 1'b1;
            o_frame_done <= i_aclken && swap;
            if (i_aclken) begin
                state     <= state_next;
                wr_idx    <= wr_idx_next;
                flush_cnt <= flush_cnt_next;
                if (swap) begin
                    o_bank <= ~o_bank;
                end
                if (err_set) begin
                    o_err_tlast <= 1'b1;
                end
            end
        end
    end

    // Stage 1: two's-complement magnitude; the most negative value maps to
    // 2^(OUTPUT_WIDTH-1), which still fits as an unsigned OUTPUT_WIDTH word.
    assign re_raw = i_axi4s_data_tdata[OUTPUT_WIDTH-1:0];
    assign im_raw = i_axi4s_data_tdata[DOUT_WIDTH+OUTPUT_WIDTH-1:DOUT_WIDTH];
    assign re_abs = re_raw[OUTPUT_WIDTH-1] ? (~re_raw + OUTPUT_WIDTH'(1)) : re_raw;
    assign im_abs = im_raw[OUTPUT_WIDTH-1] ? (~im_raw + OUTPUT_WIDTH'(1)) : im_raw;

    // Stage 2: alpha-max-plus-beta-min estimate, scaled and clamped
    assign mag_max     = (s1_a >= s1_b) ? s1_a : s1_b;
    assign mag_min     = (s1_a >= s1_b) ? s1_b : s1_a;
    assign mag_sum     = {1'b0, mag_max} + {2'b00, mag_min[OUTPUT_WIDTH-1:1]};
    assign mag_shifted = CMP_W'(mag_sum >> MAG_SHIFT);
    assign mag_limit   = CMP_W'({MAG_WIDTH{1'b1}});
    assign mag_sat     = (mag_shifted > mag_limit) ? {MAG_WIDTH{1'b1}}
                                                   : mag_shifted[MAG_WIDTH-1:0];

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (i_aclken) begin
            s1_valid <= xfer;
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (i_aclken) begin
            s1_a    <= re_abs;
            s1_b    <= im_abs;
            s1_addr <= wr_idx;
            s2_mag  <= mag_sat;
            s2_addr <= s1_addr;
        end
    end

    // Writes only ever target the hidden bank; the FSM drains the pipeline
    // before o_bank flips, so no write can straddle a swap.
    always_ff @(posedge i_aclk) begin
        if (!i_areset && i_aclken && s2_valid) begin
            mem[{~o_bank, s2_addr}] <= s2_mag;
        end
    end

    // A read issued in the swap cycle already sees the freshly completed bank
    assign rd_bank = (!i_areset && i_aclken && swap) ? ~o_bank : o_bank;

    always_ff @(posedge i_aclk) begin
        o_rd_data <= mem[{rd_bank, i_rd_addr}];
    end

endmodule

// File: tb/tb_ipsxe_fft_spectrum_buf.sv
// Directed self-checking bench for ipsxe_fft_spectrum_buf (N=16, no scaling).
module tb_ipsxe_fft_spectrum_buf;

    localparam int LOG2_FFT_LEN = 4;
    localparam int OUTPUT_WIDTH = 24;
    localparam int MAG_WIDTH    = 16;
    localparam int MAG_SHIFT    = 0;

    logic        i_aclk = 1'b0;
    logic        i_areset;
    logic        i_aclken;
    logic        i_axi4s_data_tvalid;
    logic [47:0] i_axi4s_data_tdata;
    logic        i_axi4s_data_tlast;
    logic        o_axi4s_data_tready;
    logic [3:0]  i_rd_addr;
    logic [15:0] o_rd_data;
    logic        o_bank;
    logic        o_frame_done;
    logic        o_err_tlast;

    int assertCount = 0;
    int failCount   = 0;
    int doneCount   = 0;
    bit toggleEn    = 1'b0;

    ipsxe_fft_spectrum_buf #(
        .LOG2_FFT_LEN(LOG2_FFT_LEN),
        .OUTPUT_WIDTH(OUTPUT_WIDTH),
        .MAG_WIDTH   (MAG_WIDTH),
        .MAG_SHIFT   (MAG_SHIFT)
    ) dut (
        .i_aclk              (i_aclk),
        .i_areset            (i_areset),
        .i_aclken            (i_aclken),
        .i_axi4s_data_tvalid (i_axi4s_data_tvalid),
        .i_axi4s_data_tdata  (i_axi4s_data_tdata),
        .i_axi4s_data_tlast  (i_axi4s_data_tlast),
        .o_axi4s_data_tready (o_axi4s_data_tready),
        .i_rd_addr           (i_rd_addr),
        .o_rd_data           (o_rd_data),
        .o_bank              (o_bank),
        .o_frame_done        (o_frame_done),
        .o_err_tlast         (o_err_tlast)
    );

    always #5 i_aclk = ~i_aclk;

    // Counts frame_done pulses; a pulse stretched over two cycles counts twice
    always @(negedge i_aclk) begin
        if (o_frame_done === 1'b1) doneCount++;
    end

    task automatic tick();
        @(posedge i_aclk);
        #1;
        if (toggleEn) i_aclken = ~i_aclken;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic signed [23:0] re, input logic signed [23:0] im,
                                 input logic last);
        int guard;
        guard = 0;
        i_axi4s_data_tvalid = 1'b1;
        i_axi4s_data_tdata  = {im, re};
        i_axi4s_data_tlast  = last;
        while (!(o_axi4s_data_tready && i_aclken) && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) checkOutput("xfer_timeout", 32'(guard), 32'd0);
        tick();
        i_axi4s_data_tvalid = 1'b0;
        i_axi4s_data_tlast  = 1'b0;
    endtask

    task automatic waitBank(input string tag, input logic expBank);
        int guard;
        guard = 0;
        while (o_bank !== expBank && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput(tag, 32'(o_bank), 32'(expBank));
        tick();
    endtask

    task automatic readCheck(input string tag, input logic [3:0] addr, input int expected);
        i_rd_addr = addr;
        tick();
        checkOutput(tag, 32'(o_rd_data), 32'(expected));
    endtask

    task automatic resetDut();
        i_areset = 1'b1;
        tick();
        tick();
        i_areset = 1'b0;
        tick();
    endtask

    initial begin
        int low;
        logic signed [23:0] reV, imV;

        i_areset            = 1'b1;
        i_aclken            = 1'b1;
        i_axi4s_data_tvalid = 1'b0;
        i_axi4s_data_tdata  = '0;
        i_axi4s_data_tlast  = 1'b0;
        i_rd_addr           = '0;
        tick();
        tick();
        checkOutput("rst_tready", 32'(o_axi4s_data_tready), 32'd0);
        checkOutput("rst_bank", 32'(o_bank), 32'd0);
        checkOutput("rst_done", 32'(o_frame_done), 32'd0);
        checkOutput("rst_err", 32'(o_err_tlast), 32'd0);
        i_areset = 1'b0;
        tick();
        checkOutput("post_rst_tready", 32'(o_axi4s_data_tready), 32'd1);

        $display("[TB] scenario 1: ramp frame");
        for (int k = 0; k < 16; k++) applyStimulus(24'(k), 24'sd0, k == 15);
        waitBank("s1_bank", 1'b1);
        checkOutput("s1_done_count", 32'(doneCount), 32'd1);
        checkOutput("s1_err", 32'(o_err_tlast), 32'd0);
        for (int k = 0; k < 16; k++) readCheck("s1_read", 4'(k), k);

        $display("[TB] scenario 2: magnitude corners");
        for (int k = 0; k < 16; k++) begin
            case (k)
                0:       begin reV = -24'sd3;      imV = 24'sd4;       end
                1:       begin reV = 24'sh800000;  imV = 24'sd0;       end
                2:       begin reV = 24'sh7FFFFF;  imV = 24'sh7FFFFF;  end
                default: begin reV = 24'(k);       imV = 24'sd0;       end
            endcase
            applyStimulus(reV, imV, k == 15);
        end
        waitBank("s2_bank", 1'b0);
        checkOutput("s2_done_count", 32'(doneCount), 32'd2);
        readCheck("s2_mag_3_4", 4'd0, 5);
        readCheck("s2_mag_min_neg", 4'd1, 65535);
        readCheck("s2_mag_both_max", 4'd2, 65535);
        readCheck("s2_mag_plain", 4'd3, 3);

        $display("[TB] scenario 3: early tlast");
        for (int k = 0; k < 10; k++) applyStimulus(24'(100 + k), 24'sd0, k == 9);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("s3_err", 32'(o_err_tlast), 32'd1);
        checkOutput("s3_bank_kept", 32'(o_bank), 32'd0);
        checkOutput("s3_no_pulse", 32'(doneCount), 32'd2);
        for (int k = 0; k < 16; k++) applyStimulus(24'(200 + k), 24'sd0, k == 15);
        waitBank("s3_bank_swap", 1'b1);
        checkOutput("s3_done_count", 32'(doneCount), 32'd3);
        readCheck("s3_read0", 4'd0, 200);
        readCheck("s3_read9", 4'd9, 209);
        readCheck("s3_read15", 4'd15, 215);

        $display("[TB] scenario 4: missing tlast");
        resetDut();
        checkOutput("s4_err_cleared", 32'(o_err_tlast), 32'd0);
        checkOutput("s4_bank_reset", 32'(o_bank), 32'd0);
        for (int k = 0; k < 16; k++) applyStimulus(24'(300 + k), 24'sd0, 1'b0);
        low = 0;
        while (!o_axi4s_data_tready && low < 10) begin
            low++;
            tick();
        end
        checkOutput("s4_tready_low_cycles", 32'(low), 32'd3);
        checkOutput("s4_err", 32'(o_err_tlast), 32'd1);
        checkOutput("s4_bank", 32'(o_bank), 32'd1);
        tick();
        checkOutput("s4_done_count", 32'(doneCount), 32'd4);
        readCheck("s4_read0", 4'd0, 300);
        readCheck("s4_read15", 4'd15, 315);

        $display("[TB] scenario 5: toggling clock enable");
        toggleEn = 1'b1;
        for (int k = 0; k < 16; k++) applyStimulus(24'(400 + k), 24'(k), k == 15);
        waitBank("s5_bank", 1'b0);
        toggleEn = 1'b0;
        i_aclken = 1'b1;
        tick();
        checkOutput("s5_done_count", 32'(doneCount), 32'd5);
        readCheck("s5_read0", 4'd0, 400);
        readCheck("s5_read7", 4'd7, 410);
        readCheck("s5_read15", 4'd15, 422);
        i_aclken = 1'b0;
        readCheck("s5_read8_noclken", 4'd8, 412);
        readCheck("s5_read1_noclken", 4'd1, 401);
        checkOutput("s5_bank_hold", 32'(o_bank), 32'd0);
        i_aclken = 1'b1;

        $display("[TB] scenario 6: reset mid-frame");
        resetDut();
        for (int k = 0; k < 16; k++) applyStimulus(24'(500 + k), 24'sd0, k == 15);
        waitBank("s6_first_bank", 1'b1);
        checkOutput("s6_first_done", 32'(doneCount), 32'd6);
        for (int k = 0; k < 7; k++) applyStimulus(24'(550 + k), 24'sd0, 1'b0);
        i_areset = 1'b1;
        tick();
        checkOutput("s6_rst_tready", 32'(o_axi4s_data_tready), 32'd0);
        checkOutput("s6_rst_bank", 32'(o_bank), 32'd0);
        checkOutput("s6_rst_done", 32'(o_frame_done), 32'd0);
        checkOutput("s6_rst_err", 32'(o_err_tlast), 32'd0);
        i_areset = 1'b0;
        tick();
        checkOutput("s6_tready_back", 32'(o_axi4s_data_tready), 32'd1);
        for (int k = 0; k < 16; k++) applyStimulus(24'(600 + k), 24'sd0, k == 15);
        waitBank("s6_bank", 1'b1);
        checkOutput("s6_done_count", 32'(doneCount), 32'd7);
        checkOutput("s6_err", 32'(o_err_tlast), 32'd0);
        readCheck("s6_read0", 4'd0, 600);
        readCheck("s6_read6", 4'd6, 606);
        readCheck("s6_read15", 4'd15, 615);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
